// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the register-file arbiter.
// The MEM_ARB_FIXED_PRIO_EN macro is consumed by rr_arb2, not by this package.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LS    = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SETTLE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way grant logic with last_grant round-robin state.
// With MEM_ARB_FIXED_PRIO_EN defined it reduces to fixed priority (port 1 wins).
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_arb;
  assign unused_arb = ^{clk, reset_n, update};

  always_comb begin
    gnt = '0;
    if (req[PORT_LS])         gnt[PORT_LS]    = 1'b1;
    else if (req[PORT_FETCH]) gnt[PORT_FETCH] = 1'b1;
  end
`else
  // last_grant = index of the port granted most recently; reset favours port 0.
  logic last_grant;

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              last_grant <= 1'b1;
    else if (update && |gnt)   last_grant <= gnt[PORT_LS];
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the single-port register file (IDLE/ACCESS/SETTLE).
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority to the load/store port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in_data,
  input  logic [DATA_W-1:0] mem_out_data
);

  state_t            state;
  logic              lat_we;
  logic              lat_port;
  logic              idle;
  logic [1:0]        gnt;
  logic [1:0]        hs;
  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign idle = (state == IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({req1_valid, req0_valid}),
    .update  (|hs),
    .gnt     (gnt)
  );

  assign req0_ready = idle & gnt[PORT_FETCH];
  assign req1_ready = idle & gnt[PORT_LS];
  assign hs         = {req1_valid & req1_ready, req0_valid & req0_ready};

  assign sel_port  = hs[PORT_LS];
  assign sel_we    = sel_port ? req1_we    : req0_we;
  assign sel_addr  = sel_port ? req1_addr  : req0_addr;
  assign sel_wdata = sel_port ? req1_wdata : req0_wdata;

  // mem_address/mem_in_data double as the latched request fields, so they hold between accesses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_we      <= 1'b0;
      lat_port    <= PORT_FETCH;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_address <= '0;
      mem_in_data <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_rdata  <= '0;
      rsp1_rdata  <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|hs) begin
            state       <= ACCESS;
            lat_we      <= sel_we;
            lat_port    <= sel_port;
            mem_address <= sel_addr;
            if (sel_we) mem_in_data <= sel_wdata;
            mem_wr      <= sel_we;
            mem_rd      <= ~sel_we;
          end
        end
        ACCESS: begin
          mem_wr <= 1'b0;
          mem_rd <= 1'b0;
          if (lat_we) begin
            state <= SETTLE;
          end else begin
            state <= IDLE;
            if (lat_port == PORT_LS) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= mem_out_data;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= mem_out_data;
            end
          end
        end
        SETTLE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a delayed-commit file model and a transaction-level reference.
// Honours MEM_ARB_FIXED_PRIO_EN for the expected arbitration outcome.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
  logic [7:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_wr, mem_rd;
  logic [7:0] rsp0_rdata, rsp1_rdata, mem_address, mem_in_data, mem_out_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fmem   [256] = '{default: 8'h00};
  logic [7:0] shadow [256] = '{default: 8'h00};
  logic       wp = 1'b0;
  logic [7:0] wp_a = '0, wp_d = '0;
  logic       pl_en = 1'b0;
  logic [7:0] pl_a = '0, pl_d = '0;

  int         lg = 1;
  logic [7:0] exp_rd0 = '0, exp_rd1 = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_address(mem_address), .mem_in_data(mem_in_data),
    .mem_out_data(mem_out_data)
  );

  // Register file: combinational read, write commits one cycle after the wr strobe.
  assign mem_out_data = fmem[mem_address];
  always @(posedge clk) begin
    if (pl_en)   fmem[pl_a] <= pl_d;
    else if (wp) fmem[wp_a] <= wp_d;
    wp   <= mem_wr;
    wp_a <= mem_address;
    wp_d <= mem_in_data;
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    shadow[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({mem_wr, mem_rd, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 000000",
                        {mem_wr, mem_rd, rsp0_valid, rsp1_valid, req0_ready, req1_ready});
    end
    n_cmp++;
    if ({mem_address, mem_in_data, rsp0_rdata, rsp1_rdata} !== 32'h0) begin
      n_bad++; $display("FAIL reset_data: got %h expected 00000000",
                        {mem_address, mem_in_data, rsp0_rdata, rsp1_rdata});
    end
    @(negedge clk);
    reset_n = 1'b1;
    lg = 1; exp_rd0 = '0; exp_rd1 = '0;
  endtask

  task automatic test_single_read();
    preload(8'h10, 8'hA5);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_bad++; $display("FAIL read_ready_T: got %b expected 01", {req1_ready, req0_ready});
    end
    @(negedge clk); req0_valid = 1'b0; #1;
    n_cmp++;
    if ({mem_rd, mem_wr, mem_address} !== {2'b10, 8'h10}) begin
      n_bad++; $display("FAIL read_access_T1: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=10",
                        mem_rd, mem_wr, mem_address);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({rsp1_valid, rsp0_valid, rsp0_rdata} !== {2'b01, 8'hA5}) begin
      n_bad++; $display("FAIL read_rsp_T2: got v=%b%b data=%h expected v=01 data=a5",
                        rsp1_valid, rsp0_valid, rsp0_rdata);
    end
    lg = 0; exp_rd0 = 8'hA5;
    @(negedge clk); #1;
    n_cmp++;
    if (rsp0_valid !== 1'b0 || rsp0_rdata !== 8'hA5) begin
      n_bad++; $display("FAIL read_rsp_hold: got v=%b data=%h expected v=0 data=a5", rsp0_valid, rsp0_rdata);
    end
  endtask

  task automatic test_write_raw();
    @(negedge clk);
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h20; req1_wdata = 8'h3C;
    #1;
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      n_bad++; $display("FAIL write_ready_T: got %b expected 10", {req1_ready, req0_ready});
    end
    @(negedge clk); req1_we = 1'b0; #1;
    n_cmp++;
    if ({mem_wr, mem_rd, req1_ready, mem_address, mem_in_data} !== {3'b100, 8'h20, 8'h3C}) begin
      n_bad++; $display("FAIL write_access_T1: got wr=%b rd=%b rdy=%b addr=%h din=%h expected 1 0 0 20 3c",
                        mem_wr, mem_rd, req1_ready, mem_address, mem_in_data);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({mem_wr, mem_rd, req1_ready} !== 3'b000) begin
      n_bad++; $display("FAIL write_settle_T2: got wr=%b rd=%b rdy=%b expected 000", mem_wr, mem_rd, req1_ready);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_bad++; $display("FAIL raw_ready_T3: got %b expected 1", req1_ready);
    end
    shadow[8'h20] = 8'h3C; lg = 1;
    @(negedge clk); req1_valid = 1'b0; #1;
    @(negedge clk); #1;
    n_cmp++;
    if ({rsp1_valid, rsp1_rdata} !== {1'b1, 8'h3C}) begin
      n_bad++; $display("FAIL raw_rsp: got v=%b data=%h expected v=1 data=3c", rsp1_valid, rsp1_rdata);
    end
    exp_rd1 = 8'h3C;
  endtask

  task automatic test_contention();
    int n_g = 0, cyc = 0, last_cyc = 0, rsp_cnt = 0, rsp_port = 0, bump = -1, got, exp_g;
    logic [7:0] rsp_dat = '0;
    for (int i = 0; i < 8; i++) preload(8'(8'h30 + i), 8'($urandom));
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h30;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h34;
    while ((n_g < 6 || rsp_cnt > 0) && cyc < 60) begin
      #1; cyc++;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          n_cmp++;
          if ((rsp_port == 1 && {rsp1_valid, rsp0_valid, rsp1_rdata} !== {2'b10, rsp_dat}) ||
              (rsp_port == 0 && {rsp1_valid, rsp0_valid, rsp0_rdata} !== {2'b01, rsp_dat})) begin
            n_bad++; $display("FAIL contention_rsp: got v=%b%b d0=%h d1=%h expected port %0d data %h",
                              rsp1_valid, rsp0_valid, rsp0_rdata, rsp1_rdata, rsp_port, rsp_dat);
          end
        end
      end
      got = req1_ready ? 1 : (req0_ready ? 0 : -1);
      if (got >= 0) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_g = 1;
`else
        exp_g = (lg == 1) ? 0 : 1;
`endif
        n_cmp++;
        if (got !== exp_g || (req0_ready & req1_ready) !== 1'b0) begin
          n_bad++; $display("FAIL contention_grant%0d: got rdy=%b%b expected port %0d",
                            n_g, req1_ready, req0_ready, exp_g);
        end
        if (n_g > 0) begin
          n_cmp++;
          if (cyc - last_cyc !== 2) begin
            n_bad++; $display("FAIL contention_spacing: got %0d cycles expected 2", cyc - last_cyc);
          end
        end
        last_cyc = cyc; n_g++; lg = got;
        rsp_cnt = 2; rsp_port = got;
        rsp_dat = shadow[got == 1 ? req1_addr : req0_addr];
        bump = got;
      end
      @(negedge clk);
      if (bump == 0) req0_addr = req0_addr + 8'd1;
      if (bump == 1) req1_addr = req1_addr + 8'd1;
      bump = -1;
      if (n_g == 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    if (rsp_port == 1) exp_rd1 = rsp_dat; else exp_rd0 = rsp_dat;
    n_cmp++;
    if (n_g !== 6) begin
      n_bad++; $display("FAIL contention_timeout: got %0d grants expected 6", n_g);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [7:0] wd;
    wd = 8'($urandom);
    preload(8'h51, 8'h6E);
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h50; req1_wdata = wd;
    #1;
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_bad++; $display("FAIL stall_wr_ready: got %b expected 1", req1_ready);
    end
    @(negedge clk); req1_valid = 1'b0; req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h51; #1;
    n_cmp++;
    if ({req0_ready, mem_wr} !== 2'b01) begin
      n_bad++; $display("FAIL stall_access: got rdy0=%b wr=%b expected rdy0=0 wr=1", req0_ready, mem_wr);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (req0_ready !== 1'b0) begin
      n_bad++; $display("FAIL stall_settle: got rdy0=%b expected 0", req0_ready);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_bad++; $display("FAIL stall_release: got rdy0=%b expected 1", req0_ready);
    end
    shadow[8'h50] = wd; lg = 0;
    @(negedge clk); req0_valid = 1'b0; #1;
    n_cmp++;
    if ({mem_rd, mem_address} !== {1'b1, 8'h51}) begin
      n_bad++; $display("FAIL stall_latched_addr: got rd=%b addr=%h expected rd=1 addr=51", mem_rd, mem_address);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({rsp0_valid, rsp0_rdata} !== {1'b1, 8'h6E}) begin
      n_bad++; $display("FAIL stall_rsp: got v=%b data=%h expected v=1 data=6e", rsp0_valid, rsp0_rdata);
    end
    exp_rd0 = 8'h6E;
  endtask

  task automatic test_mid_reset();
    logic [1:0] exp_rdy;
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
    @(negedge clk); req0_valid = 1'b0; #1;
    n_cmp++;
    if (mem_rd !== 1'b1) begin
      n_bad++; $display("FAIL midrst_access: got rd=%b expected 1", mem_rd);
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_rd, mem_wr, mem_address, rsp0_rdata} !== 18'h0) begin
      n_bad++; $display("FAIL midrst_async: got rd=%b wr=%b addr=%h d0=%h expected all 0",
                        mem_rd, mem_wr, mem_address, rsp0_rdata);
    end
    @(negedge clk); reset_n = 1'b1;
    lg = 1; exp_rd0 = '0; exp_rd1 = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
        n_bad++; $display("FAIL midrst_no_rsp%0d: got %b expected 00", i, {rsp1_valid, rsp0_valid});
      end
    end
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h20;
    #1;
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_rdy = 2'b10;
`else
    exp_rdy = 2'b01;
`endif
    n_cmp++;
    if ({req1_ready, req0_ready} !== exp_rdy) begin
      n_bad++; $display("FAIL midrst_first_grant: got %b expected %b", {req1_ready, req0_ready}, exp_rdy);
    end
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); #1;
    lg = exp_rdy[1] ? 1 : 0;
    if (exp_rdy[1]) exp_rd1 = shadow[8'h20]; else exp_rd0 = shadow[8'h10];
    n_cmp++;
    if (rsp0_rdata !== exp_rd0 || rsp1_rdata !== exp_rd1) begin
      n_bad++; $display("FAIL midrst_first_rsp: got d0=%h d1=%h expected d0=%h d1=%h",
                        rsp0_rdata, rsp1_rdata, exp_rd0, exp_rd1);
    end
  endtask

  task automatic test_random();
    int busy = 0, rsp_cnt = 0, rsp_port = 0, g;
    logic [7:0] rsp_dat = '0;
    logic [1:0] rv_exp, rdy_exp;
    logic drop0 = 1'b0, drop1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (drop0) begin req0_valid = 1'b0; drop0 = 1'b0; end
      if (drop1) begin req1_valid = 1'b0; drop1 = 1'b0; end
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1'b1; req0_we = 1'($urandom_range(0, 1));
        req0_addr = 8'(8'h40 + $urandom_range(0, 7)); req0_wdata = 8'($urandom);
      end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1'b1; req1_we = 1'($urandom_range(0, 1));
        req1_addr = 8'(8'h40 + $urandom_range(0, 7)); req1_wdata = 8'($urandom);
      end
      #1;
      rv_exp = 2'b00;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          rv_exp[rsp_port] = 1'b1;
          if (rsp_port == 1) exp_rd1 = rsp_dat; else exp_rd0 = rsp_dat;
        end
      end
      n_cmp++;
      if ({rsp1_valid, rsp0_valid} !== rv_exp || rsp0_rdata !== exp_rd0 || rsp1_rdata !== exp_rd1) begin
        n_bad++; $display("FAIL rand_rsp c%0d: got v=%b%b d0=%h d1=%h expected v=%b d0=%h d1=%h", c,
                          rsp1_valid, rsp0_valid, rsp0_rdata, rsp1_rdata, rv_exp, exp_rd0, exp_rd1);
      end
      g = -1;
      if (busy == 0) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (req1_valid) g = 1; else if (req0_valid) g = 0;
`else
        if (req0_valid && req1_valid) g = (lg == 1) ? 0 : 1;
        else if (req1_valid) g = 1;
        else if (req0_valid) g = 0;
`endif
      end
      rdy_exp = (g == 1) ? 2'b10 : ((g == 0) ? 2'b01 : 2'b00);
      n_cmp++;
      if ({req1_ready, req0_ready} !== rdy_exp) begin
        n_bad++; $display("FAIL rand_ready c%0d: got %b expected %b", c, {req1_ready, req0_ready}, rdy_exp);
      end
      if (g >= 0) begin
        lg = g;
        if ((g == 1) ? req1_we : req0_we) begin
          if (g == 1) shadow[req1_addr] = req1_wdata; else shadow[req0_addr] = req0_wdata;
          busy = 2;
        end else begin
          busy = 1; rsp_cnt = 2; rsp_port = g;
          rsp_dat = shadow[(g == 1) ? req1_addr : req0_addr];
        end
        if (g == 1) drop1 = 1'b1; else drop0 = 1'b1;
      end else if (busy > 0) begin
        busy--;
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_raw();
    test_contention();
    test_stall();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
